regfile_port_ctrl: RTL and testbench

Sequencer and arbiter for the register file's single read port and single write port. Up to N_RD read requesters (e.g. decode rs/rt, debug) and N_WR write requesters (e.g. writeback, debug) share the ports. The block runs the regfile's level handshake, re/we high until rack/wack high, then low until the ack drops, and returns one-cycle completion pulses. It sits between pipeline stages and `regfile`.

---
 rtl/regfile_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/regfile_port_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file port sequencer.
//   IDX_W        : register index width
//   DEF_TIMEOUT  : default cycles to wait for a regfile ack level
//   port_state_t : per-channel handshake state
package regfile_ctrl_pkg;

  localparam int unsigned IDX_W       = 5;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } port_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   in  N   request vector
//   ptr   in  PW  highest-priority position
//   grant out N   one-hot winner (all zero when no request)
//   gidx  out PW  binary index of the winner
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic        w_found;
  int unsigned w_pos;

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin
    grant   = '0;
    gidx    = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = (int'(ptr) + k) % N;
      if (!w_found && req[w_pos]) begin
        w_found      = 1'b1;
        grant[w_pos] = 1'b1;
        gidx         = PW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Sequencer/arbiter for the register file's single read and write ports.
// Each channel arbitrates its requesters round-robin, runs the level
// handshake (re/we high until ack high, then low until ack low) and
// returns a one-cycle ack pulse to the winner.
//   clk, rst                  clock, async active-high reset
//   rd_req/rd_idx/rd_ack      read requesters (packed 5-bit indices)
//   rd_data                   last completed read result
//   wr_req/wr_idx/wr_data     write requesters (packed)
//   wr_ack                    write completion pulses
//   re/r_idx/dout/rack        regfile read port
//   we/w_idx/din/wack         regfile write port
//   err                       sticky handshake timeout flag
module regfile_port_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N_RD    = 2,
  parameter int unsigned N_WR    = 2,
  parameter int unsigned REG_SZ  = 32,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD-1:0]          rd_req,
  input  logic [N_RD*IDX_W-1:0]    rd_idx,
  output logic [N_RD-1:0]          rd_ack,
  output logic [REG_SZ-1:0]        rd_data,
  input  logic [N_WR-1:0]          wr_req,
  input  logic [N_WR*IDX_W-1:0]    wr_idx,
  input  logic [N_WR*REG_SZ-1:0]   wr_data,
  output logic [N_WR-1:0]          wr_ack,
  output logic                     re,
  output logic                     we,
  output logic [IDX_W-1:0]         r_idx,
  output logic [IDX_W-1:0]         w_idx,
  output logic [REG_SZ-1:0]        din,
  input  logic [REG_SZ-1:0]        dout,
  input  logic                     rack,
  input  logic                     wack,
  output logic                     err
);

  localparam int unsigned RP_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int unsigned WP_W  = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Unpacked views of the packed requester buses
  logic [IDX_W-1:0]  w_rd_idx_a  [N_RD];
  logic [IDX_W-1:0]  w_wr_idx_a  [N_WR];
  logic [REG_SZ-1:0] w_wr_data_a [N_WR];

  for (genvar g = 0; g < N_RD; g++) begin : g_rd_unpack
    assign w_rd_idx_a[g] = rd_idx[g*IDX_W +: IDX_W];
  end
  for (genvar g = 0; g < N_WR; g++) begin : g_wr_unpack
    assign w_wr_idx_a[g]  = wr_idx[g*IDX_W +: IDX_W];
    assign w_wr_data_a[g] = wr_data[g*REG_SZ +: REG_SZ];
  end

  // ---------------- state ----------------
  port_state_t       r_rd_state, w_rd_next;
  port_state_t       r_wr_state, w_wr_next;
  logic [N_RD-1:0]   r_rd_grant;
  logic [N_WR-1:0]   r_wr_grant;
  logic [RP_W-1:0]   r_rd_ptr;
  logic [WP_W-1:0]   r_wr_ptr;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [REG_SZ-1:0] r_rd_data;
  logic [REG_SZ-1:0] r_din;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              r_err;

  // ---------------- arbitration ----------------
  logic [N_RD-1:0]   w_rd_grant;
  logic [RP_W-1:0]   w_rd_gidx;
  logic [N_WR-1:0]   w_wr_grant;
  logic [WP_W-1:0]   w_wr_gidx;
  logic [IDX_W-1:0]  w_rd_win_idx;
  logic [IDX_W-1:0]  w_wr_win_idx;
  logic [RP_W-1:0]   w_rd_ptr_nxt;
  logic [WP_W-1:0]   w_wr_ptr_nxt;

  rr_arbiter #(.N(N_RD)) u_rd_arb (
    .req   (rd_req),
    .ptr   (r_rd_ptr),
    .grant (w_rd_grant),
    .gidx  (w_rd_gidx)
  );

  rr_arbiter #(.N(N_WR)) u_wr_arb (
    .req   (wr_req),
    .ptr   (r_wr_ptr),
    .grant (w_wr_grant),
    .gidx  (w_wr_gidx)
  );

  assign w_rd_win_idx = w_rd_idx_a[w_rd_gidx];
  assign w_wr_win_idx = w_wr_idx_a[w_wr_gidx];
  assign w_rd_ptr_nxt = (w_rd_gidx == RP_W'(N_RD - 1)) ? '0 : w_rd_gidx + 1'b1;
  assign w_wr_ptr_nxt = (w_wr_gidx == WP_W'(N_WR - 1)) ? '0 : w_wr_gidx + 1'b1;

  // Read-after-write hazard: hold the read winner while a write to the same
  // nonzero index is in flight or about to be granted, so reads see new data.
  logic w_rd_haz;
  always_comb begin
    w_rd_haz = 1'b0;
    if (w_rd_win_idx != '0) begin
      if (r_wr_state != IDLE)
        w_rd_haz = (w_rd_win_idx == r_wr_idx);
      else
        w_rd_haz = (|wr_req) && (w_rd_win_idx == w_wr_win_idx);
    end
  end

  // ---------------- read channel next state ----------------
  logic w_rd_go, w_rd_to;
  always_comb begin
    w_rd_next = r_rd_state;
    w_rd_go   = 1'b0;
    w_rd_to   = 1'b0;
    unique case (r_rd_state)
      IDLE: begin
        if ((|rd_req) && !w_rd_haz) begin
          w_rd_go   = 1'b1;
          w_rd_next = (w_rd_win_idx == '0) ? DONE : ASSERT;
        end
      end
      ASSERT: begin
        if (rack) w_rd_next = RELEASE;
        else if (r_rd_cnt == CNT_LAST) begin
          w_rd_to   = 1'b1;
          w_rd_next = DONE;
        end
      end
      RELEASE: begin
        if (!rack) w_rd_next = DONE;
        else if (r_rd_cnt == CNT_LAST) begin
          w_rd_to   = 1'b1;
          w_rd_next = DONE;
        end
      end
      DONE: w_rd_next = IDLE;
      default: w_rd_next = IDLE;
    endcase
  end

  // ---------------- write channel next state ----------------
  logic w_wr_go, w_wr_to;
  always_comb begin
    w_wr_next = r_wr_state;
    w_wr_go   = 1'b0;
    w_wr_to   = 1'b0;
    unique case (r_wr_state)
      IDLE: begin
        if (|wr_req) begin
          w_wr_go   = 1'b1;
          w_wr_next = (w_wr_win_idx == '0) ? DONE : ASSERT;
        end
      end
      ASSERT: begin
        if (wack) w_wr_next = RELEASE;
        else if (r_wr_cnt == CNT_LAST) begin
          w_wr_to   = 1'b1;
          w_wr_next = DONE;
        end
      end
      RELEASE: begin
        if (!wack) w_wr_next = DONE;
        else if (r_wr_cnt == CNT_LAST) begin
          w_wr_to   = 1'b1;
          w_wr_next = DONE;
        end
      end
      DONE: w_wr_next = IDLE;
      default: w_wr_next = IDLE;
    endcase
  end

  // ---------------- read channel registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= IDLE;
      r_rd_grant <= '0;
      r_rd_ptr   <= '0;
      r_rd_idx   <= '0;
      r_rd_data  <= '0;
      r_rd_cnt   <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_rd_next != r_rd_state) r_rd_cnt <= '0;
      else if (r_rd_state == ASSERT || r_rd_state == RELEASE) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_rd_go) begin
        r_rd_grant <= w_rd_grant;
        r_rd_idx   <= w_rd_win_idx;
        r_rd_ptr   <= w_rd_ptr_nxt;
        if (w_rd_win_idx == '0) r_rd_data <= '0;
      end
      if (r_rd_state == ASSERT && rack) r_rd_data <= dout;
    end
  end

  // ---------------- write channel registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= IDLE;
      r_wr_grant <= '0;
      r_wr_ptr   <= '0;
      r_wr_idx   <= '0;
      r_din      <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_wr_next != r_wr_state) r_wr_cnt <= '0;
      else if (r_wr_state == ASSERT || r_wr_state == RELEASE) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_go) begin
        r_wr_grant <= w_wr_grant;
        r_wr_idx   <= w_wr_win_idx;
        r_din      <= w_wr_data_a[w_wr_gidx];
        r_wr_ptr   <= w_wr_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_err <= 1'b0;
    else if (w_rd_to || w_wr_to) r_err <= 1'b1;
  end

  // ---------------- outputs ----------------
  assign re      = (r_rd_state == ASSERT);
  assign we      = (r_wr_state == ASSERT);
  assign rd_ack  = (r_rd_state == DONE) ? r_rd_grant : '0;
  assign wr_ack  = (r_wr_state == DONE) ? r_wr_grant : '0;
  assign r_idx   = r_rd_idx;
  assign w_idx   = r_wr_idx;
  assign din     = r_din;
  assign rd_data = r_rd_data;
  assign err     = r_err;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural regfile whose
// acks follow re/we combinationally (gated to model a stuck regfile).
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_req;
  logic [9:0]  rd_idx;
  logic [1:0]  rd_ack;
  logic [31:0] rd_data;
  logic [1:0]  wr_req;
  logic [9:0]  wr_idx;
  logic [63:0] wr_data;
  logic [1:0]  wr_ack;
  logic        re, we;
  logic [4:0]  r_idx, w_idx;
  logic [31:0] din, dout;
  logic        rack, wack, err;

  logic        rack_en, wack_en;
  logic [31:0] mem [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.N_RD(2), .N_WR(2), .REG_SZ(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack),
    .re(re), .we(we), .r_idx(r_idx), .w_idx(w_idx), .din(din), .dout(dout),
    .rack(rack), .wack(wack), .err(err)
  );

  // regfile model
  assign rack = re & rack_en;
  assign wack = we & wack_en;
  assign dout = mem[r_idx];
  always @(posedge clk) if (we) mem[w_idx] <= din;

  task test_reset;
    @(negedge clk);
    @(negedge clk);
    total++; if ({re, we} !== 2'b00) begin bad++; $display("FAIL reset_re_we got=%b exp=00", {re, we}); end
    total++; if ({r_idx, w_idx} !== 10'd0) begin bad++; $display("FAIL reset_idx got=%h exp=0", {r_idx, w_idx}); end
    total++; if (din !== 32'd0) begin bad++; $display("FAIL reset_din got=%h exp=0", din); end
    total++; if ({rd_ack, wr_ack} !== 4'd0) begin bad++; $display("FAIL reset_acks got=%b exp=0000", {rd_ack, wr_ack}); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
  endtask

  // Both readers held: grants 0,1,0, one transaction per 4 cycles.
  task test_contention;
    logic [1:0]  exp_ack;
    logic [31:0] exp_data;
    rd_idx = {5'd9, 5'd3};
    rd_req = 2'b11;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      exp_ack = (c == 2 || c == 10) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
      total++; if (rd_ack !== exp_ack) begin bad++; $display("FAIL cont_ack c=%0d got=%b exp=%b", c, rd_ack, exp_ack); end
      total++; if (re !== (c % 4 == 0)) begin bad++; $display("FAIL cont_re c=%0d got=%b exp=%b", c, re, (c % 4 == 0)); end
      if (exp_ack != 2'b00) begin
        exp_data = (exp_ack == 2'b01) ? 32'h33 : 32'h99;
        total++; if (rd_data !== exp_data) begin bad++; $display("FAIL cont_data c=%0d got=%h exp=%h", c, rd_data, exp_data); end
      end
    end
    rd_req = 2'b00;
    @(negedge clk);
    total++; if ({rd_ack, re} !== 3'b000) begin bad++; $display("FAIL cont_idle got=%b exp=000", {rd_ack, re}); end
  endtask

  task test_single_read;
    rd_idx = {5'd0, 5'd5};
    rd_req = 2'b01;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      total++; if (re !== (c == 0)) begin bad++; $display("FAIL single_re c=%0d got=%b exp=%b", c, re, (c == 0)); end
      total++; if (rd_ack !== ((c == 2) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL single_ack c=%0d got=%b", c, rd_ack); end
      if (c == 0) begin
        total++; if (r_idx !== 5'd5) begin bad++; $display("FAIL single_ridx got=%0d exp=5", r_idx); end
      end
      if (c >= 2) begin
        total++; if (rd_data !== 32'h1234) begin bad++; $display("FAIL single_data c=%0d got=%h exp=1234", c, rd_data); end
      end
      if (c == 2) rd_req = 2'b00;
    end
  endtask

  task test_index0;
    rd_idx = 10'd0;
    rd_req = 2'b01;
    @(negedge clk);
    total++; if (rd_ack !== 2'b01) begin bad++; $display("FAIL idx0_rd_ack got=%b exp=01", rd_ack); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL idx0_rd_data got=%h exp=0", rd_data); end
    total++; if (re !== 1'b0) begin bad++; $display("FAIL idx0_re got=%b exp=0", re); end
    rd_req = 2'b00;
    wr_idx  = 10'd0;
    wr_data = {32'd0, 32'hDEAD};
    wr_req  = 2'b01;
    @(negedge clk);
    total++; if (wr_ack !== 2'b01) begin bad++; $display("FAIL idx0_wr_ack got=%b exp=01", wr_ack); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL idx0_we got=%b exp=0", we); end
    wr_req = 2'b00;
    @(negedge clk);
    total++; if ({wr_ack, we, rd_ack} !== 5'd0) begin bad++; $display("FAIL idx0_after got=%b exp=0", {wr_ack, we, rd_ack}); end
  endtask

  // Write and read of idx 7 in the same cycle: read waits for the write.
  task test_hazard;
    wr_idx  = {5'd0, 5'd7};
    wr_data = {32'd0, 32'hAA};
    wr_req  = 2'b01;
    rd_idx  = {5'd0, 5'd7};
    rd_req  = 2'b01;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      total++; if (wr_ack !== ((c == 2) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL haz_wr_ack c=%0d got=%b", c, wr_ack); end
      total++; if (rd_ack !== ((c == 6) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL haz_rd_ack c=%0d got=%b", c, rd_ack); end
      total++; if (re !== (c == 4)) begin bad++; $display("FAIL haz_re c=%0d got=%b exp=%b", c, re, (c == 4)); end
      if (c == 2) wr_req = 2'b00;
      if (c == 6) begin
        total++; if (rd_data !== 32'hAA) begin bad++; $display("FAIL haz_data got=%h exp=aa", rd_data); end
        rd_req = 2'b00;
      end
    end
  endtask

  task test_parallel;
    wr_idx  = {5'd10, 5'd0};
    wr_data = {32'h5555, 32'd0};
    wr_req  = 2'b10;
    rd_idx  = {5'd5, 5'd0};
    rd_req  = 2'b10;
    @(negedge clk);
    total++; if ({re, we} !== 2'b11) begin bad++; $display("FAIL par_re_we got=%b exp=11", {re, we}); end
    total++; if ({w_idx, din} !== {5'd10, 32'h5555}) begin bad++; $display("FAIL par_wport got=%0d/%h exp=10/5555", w_idx, din); end
    @(negedge clk);
    @(negedge clk);
    total++; if ({rd_ack, wr_ack} !== 4'b1010) begin bad++; $display("FAIL par_acks got=%b exp=1010", {rd_ack, wr_ack}); end
    total++; if (rd_data !== 32'h1234) begin bad++; $display("FAIL par_data got=%h exp=1234", rd_data); end
    rd_req = 2'b00;
    wr_req = 2'b00;
    @(negedge clk);
  endtask

  task test_timeout;
    rack_en = 1'b0;
    rd_idx  = {5'd0, 5'd9};
    rd_req  = 2'b01;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      total++; if (re !== (c < 16)) begin bad++; $display("FAIL to_re c=%0d got=%b exp=%b", c, re, (c < 16)); end
      total++; if (err !== (c == 16)) begin bad++; $display("FAIL to_err c=%0d got=%b exp=%b", c, err, (c == 16)); end
      total++; if (rd_ack !== ((c == 16) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL to_ack c=%0d got=%b", c, rd_ack); end
      if (c == 16) begin
        total++; if (rd_data !== 32'h1234) begin bad++; $display("FAIL to_data got=%h exp=1234", rd_data); end
        rd_req  = 2'b00;
        rack_en = 1'b1;
      end
    end
    @(negedge clk);
    rd_idx = {5'd0, 5'd3};
    rd_req = 2'b01;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      total++; if (rd_ack !== ((c == 2) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL to_next_ack c=%0d got=%b", c, rd_ack); end
    end
    rd_req = 2'b00;
    total++; if (rd_data !== 32'h33) begin bad++; $display("FAIL to_next_data got=%h exp=33", rd_data); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err); end
    @(negedge clk);
  endtask

  task test_reset_mid_write;
    wack_en = 1'b0;
    wr_idx  = {5'd13, 5'd12};
    wr_data = {32'h88, 32'h77};
    wr_req  = 2'b01;
    @(negedge clk);
    @(negedge clk);
    total++; if ({we, w_idx} !== {1'b1, 5'd12}) begin bad++; $display("FAIL rmw_pre got=%b/%0d exp=1/12", we, w_idx); end
    #2 rst = 1'b1;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rmw_we got=%b exp=0", we); end
    total++; if ({w_idx, din} !== 37'd0) begin bad++; $display("FAIL rmw_wport got=%0d/%h exp=0/0", w_idx, din); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmw_err got=%b exp=0", err); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rmw_rd_data got=%h exp=0", rd_data); end
    wr_req  = 2'b00;
    wack_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++; if (wr_ack !== 2'b00) begin bad++; $display("FAIL rmw_no_ack got=%b exp=00", wr_ack); end
    end
    rst    = 1'b0;
    wr_req = 2'b11;
    @(negedge clk);
    total++; if ({we, w_idx, din} !== {1'b1, 5'd12, 32'h77}) begin bad++; $display("FAIL rmw_restart got=%b/%0d/%h exp=1/12/77", we, w_idx, din); end
    @(negedge clk);
    @(negedge clk);
    total++; if (wr_ack !== 2'b01) begin bad++; $display("FAIL rmw_ack got=%b exp=01", wr_ack); end
    wr_req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rd_req = '0; rd_idx = '0;
    wr_req = '0; wr_idx = '0; wr_data = '0;
    rack_en = 1'b1; wack_en = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'h33;
    mem[5] = 32'h1234;
    mem[7] = 32'h11;
    mem[9] = 32'h99;
    test_reset;
    test_contention;
    test_single_read;
    test_index0;
    test_hazard;
    test_parallel;
    test_timeout;
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
